store_outstanding_ctrl: RTL and testbench

//  Admission control for stores leaving the store unit toward the write-through
//  D$/write buffer. Counts in-flight stores and caps them at MaxOutstandingStores.

---
 rtl/store_outstanding_ctrl.sv | 105 ++++++++++
 tb/tb_store_outstanding_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/store_outstanding_ctrl.sv
// Store admission control: caps in-flight stores, serializes non-idempotent stores,
// and drains all outstanding stores for fences with a one-cycle completion pulse.
module store_outstanding_ctrl #(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                st_req_i,
  input  logic                st_nonidem_i,
  output logic                st_gnt_o,
  input  logic                st_ack_i,
  input  logic                fence_req_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] count_o,
  output logic                busy_o,
  output logic                ack_err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StDone
  } state_e;

  state_e              state_q;
  logic                fence_done_q;
  logic [CntWidth-1:0] count_q, count_d;
  logic                nonidem_pend_q, nonidem_pend_d;
  logic                ack_err_q, ack_err_d;
  logic                issue_ok;
  logic                gnt;
  logic                ack_ok;

  // A fence request blocks grants in the very cycle it arrives.
  assign issue_ok = ~rst_i & (state_q == StIdle) & ~fence_req_i & ~nonidem_pend_q;

  always_comb begin
    gnt = 1'b0;
    if (issue_ok && st_req_i) begin
      if (st_nonidem_i) gnt = (count_q == '0);
      else              gnt = (count_q < MaxCnt);
    end
  end

  // Grants use the registered count only, so a same-cycle ack never frees a slot.
  assign ack_ok = st_ack_i & (count_q != '0);

  always_comb begin
    count_d = count_q + CntWidth'(gnt) - CntWidth'(ack_ok);

    nonidem_pend_d = nonidem_pend_q;
    if (gnt && st_nonidem_i)  nonidem_pend_d = 1'b1;
    else if (count_d == '0)   nonidem_pend_d = 1'b0;

    ack_err_d = ack_err_q | (st_ack_i & (count_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q        <= '0;
      nonidem_pend_q <= 1'b0;
      ack_err_q      <= 1'b0;
    end else begin
      count_q        <= count_d;
      nonidem_pend_q <= nonidem_pend_d;
      ack_err_q      <= ack_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fence_req_i) state_q <= StDrain;
        end
        StDrain: begin
          if (count_q == '0) begin
            state_q      <= StDone;
            fence_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign st_gnt_o     = gnt;
  assign fence_done_o = fence_done_q & ~rst_i;
  assign count_o      = count_q;
  assign busy_o       = (count_q != '0) | nonidem_pend_q | (state_q != StIdle);
  assign ack_err_o    = ack_err_q;

endmodule

// File: tb/tb_store_outstanding_ctrl.sv
// Bench for store_outstanding_ctrl: directed scenarios then random traffic, every cycle
// checked against a flag-level reference model of the admission and fence rules.
module tb_store_outstanding_ctrl;

  localparam int Max = 7;
  localparam int Cw  = $clog2(Max + 1);

  logic          clk = 1'b0;
  logic          rst_i, st_req_i, st_nonidem_i, st_gnt_o, st_ack_i, fence_req_i;
  logic          fence_done_o, busy_o, ack_err_o;
  logic [Cw-1:0] count_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stores in flight, serialization flag, fence progress, sticky error.
  int m_cnt  = 0;
  bit m_pend = 0;
  bit m_drain = 0;
  bit m_done = 0;
  bit m_err  = 0;

  always #5 clk = ~clk;

  store_outstanding_ctrl #(
    .MaxOutstanding(Max)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .st_req_i    (st_req_i),
    .st_nonidem_i(st_nonidem_i),
    .st_gnt_o    (st_gnt_o),
    .st_ack_i    (st_ack_i),
    .fence_req_i (fence_req_i),
    .fence_done_o(fence_done_o),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .ack_err_o   (ack_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input bit rst, input bit req, input bit nid, input bit ack,
                     input bit fen);
    bit exp_gnt;
    int nc;
    rst_i = rst; st_req_i = req; st_nonidem_i = nid; st_ack_i = ack; fence_req_i = fen;
    #3;
    exp_gnt = !rst && req && !m_drain && !m_done && !fen && !m_pend &&
              (nid ? (m_cnt == 0) : (m_cnt < Max));
    chk("gnt",   32'(st_gnt_o),     32'(exp_gnt));
    chk("count", 32'(count_o),      32'(m_cnt));
    chk("done",  32'(fence_done_o), 32'(m_done && !rst));
    chk("busy",  32'(busy_o),       32'(m_cnt != 0 || m_pend || m_drain || m_done));
    chk("err",   32'(ack_err_o),    32'(m_err));
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_drain = 0; m_done = 0; m_err = 0;
    end else begin
      if (ack && m_cnt == 0) m_err = 1;
      nc = m_cnt + int'(exp_gnt) - ((ack && m_cnt > 0) ? 1 : 0);
      if (exp_gnt && nid) m_pend = 1;
      else if (nc == 0)   m_pend = 0;
      if (m_done) m_done = 0;
      else if (m_drain) begin
        if (m_cnt == 0) begin m_drain = 0; m_done = 1; end
      end else if (fen) m_drain = 1;
      m_cnt = nc;
    end
  endtask

  initial begin
    bit seen_done;
    rst_i = 1; st_req_i = 0; st_nonidem_i = 0; st_ack_i = 0; fence_req_i = 0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0);
    chk("reset_count", 32'(count_o), 0);

    // Fill to the cap, then one ack frees a slot for the cycle after.
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
    chk("cap_count", 32'(count_o), 7);
    cyc(0, 1, 0, 1, 0);
    chk("after_ack", 32'(count_o), 6);
    cyc(0, 1, 0, 0, 0);
    chk("resume", 32'(count_o), 7);

    // Simultaneous grant and ack hold the count.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("gnt_ack_hold", 32'(count_o), 3);

    // Non-idempotent waits for empty, then blocks a following normal store.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    chk("nonidem_cnt", 32'(count_o), 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    chk("post_nonidem", 32'(count_o), 1);

    // Fence drain from count 3 with acks at t+2, t+4, t+5.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, (i == 2 || i == 4 || i == 5), i < 7);
    chk("fence_cnt", 32'(count_o), 0);
    cyc(0, 0, 0, 0, 0);

    // Ack on empty is sticky and does not disturb counting.
    cyc(0, 0, 0, 1, 0);
    chk("err_set", 32'(ack_err_o), 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("err_sticky", 32'(ack_err_o), 1);
    chk("cnt_after_err", 32'(count_o), 1);

    // Reset during a drain aborts it without a done pulse.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (fence_done_o) seen_done = 1;
      cyc(0, 0, 0, 0, 0);
    end
    chk("abort_done", 32'(seen_done), 0);
    chk("abort_cnt", 32'(count_o), 0);
    chk("abort_err", 32'(ack_err_o), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
